mips_multicycle_control: RTL and testbench

- Multi-cycle MIPS control FSM. It replaces the single-cycle opcode decoder in the datapath top.
- Sequences fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects per state.
- Memory accesses wait on a ready handshake, bounded by a timeout counter.
- Illegal opcodes and memory timeouts raise a sticky trap that halts sequencing until cleared.

---
 rtl/mips_ctrl_pkg.sv | 78 +++++++
 rtl/mips_opclass_decode.sv | 55 +++++
 rtl/mips_multicycle_control.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
// Datapath mux encodings here must match the datapath top.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StWbR     = 4'd3,
    StExecI   = 4'd4,
    StWbI     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWr   = 4'd8,
    StWbMem   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsBranch,
    ClsJump,
    ClsImm,
    ClsLoad,
    ClsStore,
    ClsIllegal
  } opclass_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BLTZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LH    = 6'd33;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC4 = 2'b10;

  localparam logic       ALU_A_PC = 1'b0;
  localparam logic       ALU_A_RS = 1'b1;

  localparam logic [1:0] ALU_B_RT    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR  = 2'b01;
  localparam logic [1:0] ALU_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_B_SHIFT = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mips_opclass_decode.sv
// Combinational opcode classifier: instruction class, load/store size and link flag.
module mips_opclass_decode
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  output opclass_e       op_class_o,
  output logic [1:0]     mem_size_o,
  output logic           link_o
);

  always_comb begin
    op_class_o = ClsIllegal;
    mem_size_o = MEM_NONE;
    link_o     = 1'b0;
    case (opcode_i)
      OPW'(OP_RTYPE): op_class_o = ClsR;
      OPW'(OP_BLTZ), OPW'(OP_BEQ), OPW'(OP_BNE): op_class_o = ClsBranch;
      OPW'(OP_J): op_class_o = ClsJump;
      OPW'(OP_JAL): begin
        op_class_o = ClsJump;
        link_o     = 1'b1;
      end
      OPW'(OP_ADDI), OPW'(OP_SLTI), OPW'(OP_ANDI), OPW'(OP_ORI), OPW'(OP_XORI):
        op_class_o = ClsImm;
      OPW'(OP_LB): begin
        op_class_o = ClsLoad;
        mem_size_o = MEM_BYTE;
      end
      OPW'(OP_LH): begin
        op_class_o = ClsLoad;
        mem_size_o = MEM_HALF;
      end
      OPW'(OP_LW): begin
        op_class_o = ClsLoad;
        mem_size_o = MEM_WORD;
      end
      OPW'(OP_SB): begin
        op_class_o = ClsStore;
        mem_size_o = MEM_BYTE;
      end
      OPW'(OP_SH): begin
        op_class_o = ClsStore;
        mem_size_o = MEM_HALF;
      end
      OPW'(OP_SW): begin
        op_class_o = ClsStore;
        mem_size_o = MEM_WORD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences instruction phases, drives datapath
// strobes/selects, and traps on illegal opcodes or memory handshake timeouts.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 6,
  parameter int unsigned ALUOPW  = 7,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  input  logic              trap_clear,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              ir_write,
  output logic              i_or_d,
  output logic [1:0]        mem_read,
  output logic              mem_write,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic [1:0]        pc_source,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [3:0]        state_o
);

  localparam logic [ALUOPW-1:0] AluAdd = ALUOPW'({1'b1, OPW'(OP_ADDI)});

  state_e         state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  opclass_e       cls_q, cls_d;
  logic [1:0]     size_q, size_d;
  logic           link_q, link_d;
  logic           trap_q, trap_d;
  logic [1:0]     cause_q, cause_d;

  opclass_e       dec_class;
  logic [1:0]     dec_size;
  logic           dec_link;
  logic           wait_st;
  logic           timed_out;
  logic [ALUOPW-1:0] alu_op_latched;

  // The branch condition is resolved in the datapath; control never looks at it.
  logic unused_zero;
  assign unused_zero = zero;

  mips_opclass_decode #(
    .OPW (OPW)
  ) u_decode (
    .opcode_i   (opcode),
    .op_class_o (dec_class),
    .mem_size_o (dec_size),
    .link_o     (dec_link)
  );

  assign wait_st        = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // Ready in the cycle the count would reach TIMEOUT still wins.
  assign timed_out      = wait_st && !mem_ready && (cnt_q == CNTW'(TIMEOUT - 1));
  assign alu_op_latched = ALUOPW'({1'b1, opcode_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    cls_d    = cls_q;
    size_d   = size_q;
    link_d   = link_q;
    trap_d   = trap_q;
    cause_d  = cause_q;

    unique case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        opcode_d = opcode;
        cls_d    = dec_class;
        size_d   = dec_size;
        link_d   = dec_link;
        unique case (dec_class)
          ClsR:              state_d = StExecR;
          ClsImm:            state_d = StExecI;
          ClsLoad, ClsStore: state_d = StMemAddr;
          ClsBranch:         state_d = StBranch;
          ClsJump:           state_d = StJump;
          default: begin
            state_d = StTrap;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemAddr: state_d = (cls_q == ClsLoad) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StWbMem;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StWbR, StWbI, StWbMem, StBranch, StJump: state_d = StFetch;
      StTrap: begin
        if (trap_clear) begin
          state_d = StFetch;
          trap_d  = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = StFetch;
    endcase

    if (timed_out) begin
      state_d = StTrap;
      trap_d  = 1'b1;
      cause_d = CAUSE_TIMEOUT;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_st && !mem_ready) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      cnt_q    <= '0;
      opcode_q <= '0;
      cls_q    <= ClsR;
      size_q   <= MEM_NONE;
      link_q   <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      cls_q    <= cls_d;
      size_q   <= size_d;
      link_q   <= link_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = MEM_NONE;
    mem_write     = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = WB_SRC_ALU;
    reg_write     = 1'b0;
    alu_src_a     = ALU_A_PC;
    alu_src_b     = ALU_B_RT;
    alu_op        = '0;
    pc_source     = PC_SRC_ALU;

    unique case (state_q)
      StFetch: begin
        mem_read  = MEM_WORD;
        alu_src_b = ALU_B_FOUR;
        alu_op    = AluAdd;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = ALU_B_SHIFT;
        alu_op    = AluAdd;
      end
      StExecR: alu_src_a = ALU_A_RS;
      StWbR: begin
        reg_dst   = REG_DST_RD;
        reg_write = 1'b1;
      end
      StExecI, StMemAddr: begin
        alu_src_a = ALU_A_RS;
        alu_src_b = ALU_B_IMM;
        alu_op    = alu_op_latched;
      end
      StWbI: reg_write = 1'b1;
      StMemRd: begin
        i_or_d   = 1'b1;
        mem_read = size_q;
      end
      StMemWr: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      StWbMem: begin
        mem_to_reg = WB_SRC_MEM;
        reg_write  = 1'b1;
      end
      StBranch: begin
        alu_src_a     = ALU_A_RS;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        alu_op        = alu_op_latched;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
        if (link_q) begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_R31;
          mem_to_reg = WB_SRC_PC4;
        end
      end
      default: ;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: random instruction streams and
// handshake stalls checked cycle by cycle against an instruction-level model.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 4;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       irw;
    logic       iord;
    logic [1:0] mrd;
    logic       mwr;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [6:0] aop;
    logic [1:0] psrc;
  } outs_t;

  logic       clk, rst_n, zero, mem_ready, trap_clear;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_write, reg_write, alu_src_a;
  logic [1:0] mem_read, reg_dst, mem_to_reg, alu_src_b, pc_source, trap_cause;
  logic [6:0] alu_op;
  logic       trap;
  logic [3:0] state_o;

  int checks;
  int failures;

  logic [5:0] legal_ops [17] = '{6'd0, 6'd1, 6'd4, 6'd5, 6'd2, 6'd3, 6'd8, 6'd10, 6'd12,
                                 6'd13, 6'd14, 6'd32, 6'd33, 6'd35, 6'd40, 6'd41, 6'd43};

  mips_multicycle_control #(
    .OPW     (6),
    .ALUOPW  (7),
    .TIMEOUT (TB_TIMEOUT),
    .CNTW    (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .trap_clear    (trap_clear),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 R, 1 branch, 2 jump, 3 imm, 4 load, 5 store, 6 illegal
  function automatic int op_class(input logic [5:0] op);
    if (op == 6'd0) return 0;
    if (op inside {6'd1, 6'd4, 6'd5}) return 1;
    if (op inside {6'd2, 6'd3}) return 2;
    if (op inside {6'd8, 6'd10, 6'd12, 6'd13, 6'd14}) return 3;
    if (op inside {6'd32, 6'd33, 6'd35}) return 4;
    if (op inside {6'd40, 6'd41, 6'd43}) return 5;
    return 6;
  endfunction

  function automatic logic [1:0] load_size(input logic [5:0] op);
    if (op == 6'd32) return 2'b01;
    if (op == 6'd33) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic rnd_clr();
    return ($urandom_range(3) == 0);
  endfunction

  // Expected outputs per phase; strobes are always cared about, selects only where defined.
  function automatic void model_outs(input state_e ph, input logic [5:0] op, input logic rdy,
                                     output outs_t e, output outs_t c);
    e = '0;
    c = '0;
    c.pcw = 1'b1; c.pcwc = 1'b1; c.irw = 1'b1; c.mwr = 1'b1; c.rw = 1'b1; c.mrd = 2'b11;
    case (ph)
      StFetch: begin
        e.mrd = 2'b11; e.asb = 2'b01; e.aop = 7'h48; e.pcw = rdy; e.irw = rdy;
        c.iord = 1'b1; c.asa = 1'b1; c.asb = 2'b11; c.psrc = 2'b11; c.aop = 7'h7f;
      end
      StDecode: begin
        e.asb = 2'b11; e.aop = 7'h48;
        c.asa = 1'b1; c.asb = 2'b11; c.aop = 7'h7f;
      end
      StExecR: begin
        e.asa = 1'b1;
        c.asa = 1'b1; c.asb = 2'b11; c.aop = 7'h7f;
      end
      StWbR: begin
        e.rdst = 2'b01; e.rw = 1'b1;
        c.rdst = 2'b11; c.m2r = 2'b11;
      end
      StExecI, StMemAddr: begin
        e.asa = 1'b1; e.asb = 2'b10; e.aop = {1'b1, op};
        c.asa = 1'b1; c.asb = 2'b11; c.aop = 7'h7f;
      end
      StWbI: begin
        e.rw = 1'b1;
        c.rdst = 2'b11;
      end
      StMemRd: begin
        e.iord = 1'b1; e.mrd = load_size(op);
        c.iord = 1'b1;
      end
      StMemWr: begin
        e.iord = 1'b1; e.mwr = 1'b1;
        c.iord = 1'b1;
      end
      StWbMem: begin
        e.m2r = 2'b01; e.rw = 1'b1;
        c.rdst = 2'b11; c.m2r = 2'b11;
      end
      StBranch: begin
        e.asa = 1'b1; e.pcwc = 1'b1; e.psrc = 2'b01; e.aop = {1'b1, op};
        c.asa = 1'b1; c.asb = 2'b11; c.psrc = 2'b11; c.aop = 7'h7f;
      end
      StJump: begin
        e.pcw = 1'b1; e.psrc = 2'b10;
        c.psrc = 2'b11;
        if (op == 6'd3) begin
          e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10;
          c.rdst = 2'b11; c.m2r = 2'b11;
        end
      end
      default: ;
    endcase
  endfunction

  // One cycle: drive inputs away from the rising edge, check, then advance to the next negedge.
  task automatic drive_and_check(input state_e ph, input logic [5:0] op, input logic rdy,
                                 input logic clr, input logic [5:0] lop,
                                 input logic [1:0] xcause);
    outs_t e, c, a;
    opcode = op; mem_ready = rdy; trap_clear = clr; zero = 1'($urandom);
    #1;
    model_outs(ph, lop, rdy, e, c);
    a = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg,
         reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    checks++;
    if ((a & c) !== (e & c)) begin
      failures++;
      $display("FAIL outs ph=%s op=%0d rdy=%b act=%h exp=%h", ph.name(), lop, rdy, a & c, e & c);
    end
    checks++;
    if (state_o !== ph) begin
      failures++;
      $display("FAIL state act=%0d exp=%0d (%s)", state_o, ph, ph.name());
    end
    checks++;
    if (trap !== (ph == StTrap)) begin
      failures++;
      $display("FAIL trap ph=%s act=%b exp=%b", ph.name(), trap, ph == StTrap);
    end
    if (ph == StTrap) begin
      checks++;
      if (trap_cause !== xcause) begin
        failures++;
        $display("FAIL trap_cause act=%b exp=%b", trap_cause, xcause);
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_trap(input logic [1:0] cause, input int hold);
    for (int k = 0; k < hold; k++) begin
      drive_and_check(StTrap, 6'($urandom), 1'($urandom), 1'b0, 6'd0, cause);
    end
    drive_and_check(StTrap, 6'($urandom), 1'($urandom), 1'b1, 6'd0, cause);
  endtask

  // Walk one instruction through its phase list; stall_n >= 0 forces that many
  // not-ready cycles in stall_ph before ready, otherwise ready is random.
  task automatic run_instr(input logic [5:0] op, input int rdy_pct, input state_e stall_ph,
                           input int stall_n, input int trap_hold);
    state_e seq[$];
    int     cls;
    int     waits;
    logic   rdy;
    bit     done;
    cls = op_class(op);
    seq.push_back(StFetch);
    seq.push_back(StDecode);
    case (cls)
      0: begin seq.push_back(StExecR); seq.push_back(StWbR); end
      1: seq.push_back(StBranch);
      2: seq.push_back(StJump);
      3: begin seq.push_back(StExecI); seq.push_back(StWbI); end
      4: begin seq.push_back(StMemAddr); seq.push_back(StMemRd); seq.push_back(StWbMem); end
      5: begin seq.push_back(StMemAddr); seq.push_back(StMemWr); end
      default: ;
    endcase
    foreach (seq[i]) begin
      if (seq[i] inside {StFetch, StMemRd, StMemWr}) begin
        waits = 0;
        done  = 1'b0;
        while (!done) begin
          if (stall_n >= 0 && seq[i] == stall_ph) rdy = (waits >= stall_n);
          else rdy = ($urandom_range(99) < rdy_pct);
          drive_and_check(seq[i], 6'($urandom), rdy, rnd_clr(), op, 2'b00);
          if (rdy) begin
            done = 1'b1;
          end else begin
            waits++;
            if (waits == TB_TIMEOUT) begin
              expect_trap(2'b10, trap_hold);
              return;
            end
          end
        end
      end else begin
        drive_and_check(seq[i], (seq[i] == StDecode) ? op : 6'($urandom), 1'($urandom),
                        rnd_clr(), op, 2'b00);
      end
    end
    if (cls == 6) expect_trap(2'b01, trap_hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; trap_clear = 1'b0; opcode = '0; zero = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (state_o !== StFetch || trap !== 1'b0 || trap_cause !== 2'b00) begin
      failures++;
      $display("FAIL reset_state state=%0d trap=%b cause=%b", state_o, trap, trap_cause);
    end
    checks++;
    if ({pc_write, ir_write, reg_write, mem_write, mem_read} !== 6'b000011) begin
      failures++;
      $display("FAIL reset_outs act=%b exp=000011",
               {pc_write, ir_write, reg_write, mem_write, mem_read});
    end
    rst_n = 1'b1;
    // Abandon a load while it waits in MEM_RD.
    drive_and_check(StFetch, 6'($urandom), 1'b1, 1'b0, 6'd35, 2'b00);
    drive_and_check(StDecode, 6'd35, 1'b1, 1'b0, 6'd35, 2'b00);
    drive_and_check(StMemAddr, 6'($urandom), 1'b1, 1'b0, 6'd35, 2'b00);
    drive_and_check(StMemRd, 6'($urandom), 1'b0, 1'b0, 6'd35, 2'b00);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (state_o !== StFetch || reg_write !== 1'b0 || trap !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset state=%0d reg_write=%b trap=%b", state_o, reg_write, trap);
      end
      if (k == 0) @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    run_instr(6'd0, 100, StFetch, -1, 0);
    run_instr(6'd0, 50, StFetch, -1, 0);
  endtask

  task automatic test_load_wait();
    run_instr(6'd35, 100, StMemRd, 3, 0);
    run_instr(6'd32, 100, StMemRd, 1, 0);
  endtask

  task automatic test_jump();
    run_instr(6'd3, 100, StFetch, -1, 0);
    run_instr(6'd2, 100, StFetch, -1, 0);
    run_instr(6'd4, 100, StFetch, -1, 0);
  endtask

  task automatic test_illegal();
    run_instr(6'd63, 100, StFetch, -1, 10);
    run_instr(6'd7, 100, StFetch, -1, 2);
    run_instr(6'd0, 100, StFetch, -1, 0);
  endtask

  task automatic test_timeout();
    run_instr(6'd43, 100, StMemWr, 4, 3);
    run_instr(6'd43, 100, StMemWr, 3, 0);
    run_instr(6'd33, 100, StMemRd, 4, 1);
    run_instr(6'd13, 100, StFetch, 4, 1);
    run_instr(6'd13, 100, StFetch, 3, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) run_instr(legal_ops[i], 100, StFetch, -1, 0);
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(99) < 85) op = legal_ops[$urandom_range(16)];
      else op = 6'($urandom);
      run_instr(op, 70, StFetch, -1, 1 + int'($urandom_range(3)));
    end
    run_instr(6'd0, 100, StFetch, -1, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    opcode = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    trap_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_wait();
    test_jump();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
